fft_sdf_delay_buf: RTL and testbench

Parametrised delay buffer for one single-path delay-feedback (SDF) radix-2 FFT stage. Each beat is a LANES-wide vector of complex samples. The block stores DEPTH beats in a circular register buffer and tracks the fill and butterfly half-frames. In the butterfly half-frame it stores butterfly feedback (difference) results in place of raw input. It sits between the stage input and the butterfly/twiddle logic, and replaces the fixed fill-and-pulse shift buffer with a continuous, gap-tolerant, frame-aware buffer.

---
 rtl/fft_sdf_delay_buf.sv | 85 ++++++++
 tb/tb_fft_sdf_delay_buf.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fft_sdf_delay_buf.sv
// Circular delay buffer for one SDF radix-2 FFT stage: DEPTH beats of LANES complex
// samples, frame-aware (fill half stores din, butterfly half stores fb).
module fft_sdf_delay_buf #(
    parameter int DATA_WIDTH = 9,
    parameter int DEPTH      = 16,
    parameter int LANES      = 16
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 clr,
    input  logic                                 din_valid,
    input  logic signed [LANES*DATA_WIDTH-1:0]   din_i,
    input  logic signed [LANES*DATA_WIDTH-1:0]   din_q,
    input  logic signed [LANES*DATA_WIDTH-1:0]   fb_i,
    input  logic signed [LANES*DATA_WIDTH-1:0]   fb_q,
    output logic signed [LANES*DATA_WIDTH-1:0]   dout_i,
    output logic signed [LANES*DATA_WIDTH-1:0]   dout_q,
    output logic                                 dout_valid,
    output logic                                 bfly_en,
    output logic                                 blk_last,
    output logic [$clog2(2*DEPTH)-1:0]           phase
);

    localparam int BW  = LANES * DATA_WIDTH;
    localparam int PW  = $clog2(2 * DEPTH);
    localparam int WPW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PW-1:0]  CNT_HALF = PW'(DEPTH);
    localparam logic [PW-1:0]  CNT_LAST = PW'(2 * DEPTH - 1);
    localparam logic [WPW-1:0] WP_LAST  = WPW'(DEPTH - 1);

    logic [BW-1:0]  r_mem_i [DEPTH];
    logic [BW-1:0]  r_mem_q [DEPTH];
    logic [WPW-1:0] r_wp;
    logic [PW-1:0]  r_cnt;
    logic           r_primed;

    logic w_accept;
    logic w_bfly;

    assign w_accept = din_valid & ~clr;
    assign w_bfly   = (r_cnt >= CNT_HALF);

    // NOTE: the storage is reset explicitly because a freshly reset stage must present
    // zeros on dout; that forces flops rather than a RAM macro, which suits this size.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_mem_i[e] <= '0;
                r_mem_q[e] <= '0;
            end
        end else if (w_accept) begin
            r_mem_i[r_wp] <= w_bfly ? fb_i : din_i;
            r_mem_q[r_wp] <= w_bfly ? fb_q : din_q;
        end
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values
    // and the write above sees the same r_wp/r_cnt as this block.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt    <= '0;
            r_wp     <= '0;
            r_primed <= 1'b0;
        end else if (clr) begin
            r_cnt    <= '0;
            r_wp     <= '0;
            r_primed <= 1'b0;
        end else if (din_valid) begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            // Explicit wrap: DEPTH need not be a power of two.
            r_wp  <= (r_wp == WP_LAST) ? '0 : r_wp + 1'b1;
            if (r_wp == WP_LAST)
                r_primed <= 1'b1;
        end
    end

    assign dout_i     = r_mem_i[r_wp];
    assign dout_q     = r_mem_q[r_wp];
    assign bfly_en    = w_bfly;
    assign blk_last   = din_valid & (r_cnt == CNT_LAST);
    assign dout_valid = din_valid & r_primed;
    assign phase      = r_cnt;

endmodule

// File: tb/tb_fft_sdf_delay_buf.sv
// Drives a DEPTH=4 and a DEPTH=3 buffer with shared stimulus and compares both against
// a per-beat model of the delay/frame rules.
module tb_fft_sdf_delay_buf;

    localparam int DW = 9;
    localparam int LN = 2;
    localparam int BW = DW * LN;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          clr = 1'b0;
    logic          din_valid = 1'b0;
    logic [BW-1:0] din_i = '0, din_q = '0, fb_i = '0, fb_q = '0;

    logic [BW-1:0] o_i [2];
    logic [BW-1:0] o_q [2];
    logic          o_v [2];
    logic          o_b [2];
    logic          o_l [2];
    logic [2:0]    o_ph [2];

    int vectors = 0;
    int errors  = 0;

    int            dep [2] = '{4, 3};
    logic [BW-1:0] m_i [2][4];
    logic [BW-1:0] m_q [2][4];
    int            n [2];

    always #5 clk = ~clk;

    fft_sdf_delay_buf #(.DATA_WIDTH(DW), .DEPTH(4), .LANES(LN)) u_d4 (
        .clk(clk), .rstn(rstn), .clr(clr), .din_valid(din_valid),
        .din_i(din_i), .din_q(din_q), .fb_i(fb_i), .fb_q(fb_q),
        .dout_i(o_i[0]), .dout_q(o_q[0]), .dout_valid(o_v[0]),
        .bfly_en(o_b[0]), .blk_last(o_l[0]), .phase(o_ph[0])
    );

    fft_sdf_delay_buf #(.DATA_WIDTH(DW), .DEPTH(3), .LANES(LN)) u_d3 (
        .clk(clk), .rstn(rstn), .clr(clr), .din_valid(din_valid),
        .din_i(din_i), .din_q(din_q), .fb_i(fb_i), .fb_q(fb_q),
        .dout_i(o_i[1]), .dout_q(o_q[1]), .dout_valid(o_v[1]),
        .bfly_en(o_b[1]), .blk_last(o_l[1]), .phase(o_ph[1])
    );

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[D=%0d] observed=%0h expected=%0h", tag, dep[k], obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            n[k] = 0;
            for (int e = 0; e < 4; e++) begin
                m_i[k][e] = '0;
                m_q[k][e] = '0;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int d, c;
            d = dep[k];
            c = n[k] % (2 * d);
            chk("dout_i", k, 32'(o_i[k]), 32'(m_i[k][n[k] % d]));
            chk("dout_q", k, 32'(o_q[k]), 32'(m_q[k][n[k] % d]));
            chk("phase", k, 32'(o_ph[k]), 32'(c));
            chk("bfly_en", k, 32'(o_b[k]), 32'(c >= d));
            chk("blk_last", k, 32'(o_l[k]), 32'(din_valid && c == 2 * d - 1));
            chk("dout_valid", k, 32'(o_v[k]), 32'(din_valid && n[k] >= d));
        end
    endtask

    // One clock: drive, check mid-cycle, then apply the accepted beat to the model.
    // d0/f0 >= 0 force lane0 of din_i/fb_i; e0 >= 0 is a directed dout_i lane0 for D=4.
    task automatic step(input bit v, input bit c, input int d0, input int f0, input int e0);
        din_valid = v;
        clr       = c;
        din_i = BW'($urandom);
        din_q = BW'($urandom);
        fb_i  = BW'($urandom);
        fb_q  = BW'($urandom);
        if (d0 >= 0) din_i[DW-1:0] = DW'(d0);
        if (f0 >= 0) fb_i[DW-1:0]  = DW'(f0);
        #3;
        check_all();
        if (e0 >= 0) chk("dout_i_lane0", 0, 32'(o_i[0][DW-1:0]), 32'(e0));
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (c) begin
                n[k] = 0;
            end else if (v) begin
                int d, idx;
                d   = dep[k];
                idx = n[k] % d;
                if ((n[k] % (2 * d)) >= d) begin
                    m_i[k][idx] = fb_i;
                    m_q[k][idx] = fb_q;
                end else begin
                    m_i[k][idx] = din_i;
                    m_q[k][idx] = din_q;
                end
                n[k]++;
            end
        end
        #1;
    endtask

    task automatic directed_frame();
        for (int b = 0; b < 12; b++) begin
            int e;
            if (b >= 4 && b < 8)      e = b - 3;
            else if (b >= 8)          e = 100 + b - 4;
            else                      e = -1;
            step(1'b1, 1'b0, b + 1, 100 + b, e);
        end
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Continuous fill / butterfly / feedback frame.
        directed_frame();

        // Three idle cycles after every beat.
        for (int b = 0; b < 12; b++) begin
            step(1'b1, 1'b0, -1, -1, -1);
            for (int g = 0; g < 3; g++) step(1'b0, 1'b0, -1, -1, -1);
        end

        // Random gaps.
        for (int b = 0; b < 40; b++) step(1'($urandom_range(0, 1)), 1'b0, -1, -1, -1);

        // clr colliding with a beat at phase 5.
        step(1'b0, 1'b1, -1, -1, -1);
        for (int b = 0; b < 5; b++) step(1'b1, 1'b0, -1, -1, -1);
        chk("phase_before_clr", 0, 32'(o_ph[0]), 32'd5);
        step(1'b1, 1'b1, -1, -1, -1);
        for (int b = 0; b < 10; b++) step(1'b1, 1'b0, -1, -1, -1);

        // Async reset pulse mid-cycle in the butterfly half.
        step(1'b0, 1'b1, -1, -1, -1);
        for (int b = 0; b < 5; b++) step(1'b1, 1'b0, -1, -1, -1);
        din_valid = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_dout_i", k, 32'(o_i[k]), 32'd0);
            chk("rst_dout_q", k, 32'(o_q[k]), 32'd0);
            chk("rst_phase", k, 32'(o_ph[k]), 32'd0);
            chk("rst_bfly_en", k, 32'(o_b[k]), 32'd0);
            chk("rst_blk_last", k, 32'(o_l[k]), 32'd0);
            chk("rst_dout_valid", k, 32'(o_v[k]), 32'd0);
        end
        model_reset();
        #2;
        din_valid = 1'b0;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        directed_frame();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
